fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined processor. Holds the program counter, drives the instruction-memory address, selects the next PC from the control unit's PC-source/kill outputs, and presents the fetched instruction to decode. Sits directly upstream of the decode/control stage: it consumes `stall` from hazard detection and `pc_src`/`kill` from PC control, and feeds the opcode/register fields they decode.

---
 rtl/fetch_stage.sv | 67 ++++++
 tb/tb_fetch_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, next-PC select and IF/ID register feeding decode.
module fetch_stage #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              kill,
    input  logic [1:0]        pc_src,
    input  logic [DATA_W-1:0] jump_target,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [DATA_W-1:0] ret_target,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_pc_plus1,
    output logic              id_valid,
    output logic [15:0]       fetch_count,
    output logic [15:0]       kill_count,
    output logic [15:0]       stall_count
);
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] next_pc;

    assign imem_addr = pc;
    assign pc_inc    = pc + {{(DATA_W-1){1'b0}}, 1'b1};

    always_comb begin
        next_pc = pc_src == 2'd0 ? pc_inc :
                  pc_src == 2'd1 ? jump_target :
                  pc_src == 2'd2 ? branch_target : ret_target;
    end

    // Counters add their own not-yet-saturated flag, so they stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            id_instr    <= NOP_INSTR;
            id_pc       <= '0;
            id_pc_plus1 <= '0;
            id_valid    <= 1'b0;
            fetch_count <= '0;
            kill_count  <= '0;
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= stall_count + {15'd0, ~&stall_count};
        end else if (kill) begin
            pc          <= next_pc;
            id_instr    <= NOP_INSTR;
            id_pc       <= pc;
            id_pc_plus1 <= pc_inc;
            id_valid    <= 1'b0;
            kill_count  <= kill_count + {15'd0, ~&kill_count};
        end else begin
            pc          <= pc_inc;
            id_instr    <= imem_rdata;
            id_pc       <= pc;
            id_pc_plus1 <= pc_inc;
            id_valid    <= 1'b1;
            fetch_count <= fetch_count + {15'd0, ~&fetch_count};
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus checked against a behavioural fetch model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, stall, kill;
    logic [1:0]  pc_src;
    logic [15:0] jump_target, branch_target, ret_target;
    logic [15:0] imem_addr, imem_rdata, pc, id_instr, id_pc, id_pc_plus1;
    logic        id_valid;
    logic [15:0] fetch_count, kill_count, stall_count;

    int checks = 0;
    int errors = 0;

    int m_pc, m_instr, m_idpc, m_idpc1, m_valid, m_fc, m_kc, m_sc;
    bit m_ok = 1'b0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .kill(kill), .pc_src(pc_src),
        .jump_target(jump_target), .branch_target(branch_target), .ret_target(ret_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus1(id_pc_plus1), .id_valid(id_valid),
        .fetch_count(fetch_count), .kill_count(kill_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic int mem(int a);
        return (32'h1000 + a) & 32'hFFFF;
    endfunction

    assign imem_rdata = 16'(mem(int'(imem_addr)));

    function automatic int sat(int c);
        return c >= 65535 ? 65535 : c + 1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1'b1;
            m_pc = 0; m_instr = 0; m_idpc = 0; m_idpc1 = 0; m_valid = 0;
            m_fc = 0; m_kc = 0; m_sc = 0;
        end else if (m_ok) begin
            if (stall) m_sc = sat(m_sc);
            else if (kill) begin
                m_instr = 0; m_valid = 0;
                m_idpc  = m_pc; m_idpc1 = (m_pc + 1) % 65536;
                m_pc    = pc_src == 0 ? (m_pc + 1) % 65536 : pc_src == 1 ? int'(jump_target) :
                          pc_src == 2 ? int'(branch_target) : int'(ret_target);
                m_kc    = sat(m_kc);
            end else begin
                m_instr = mem(m_pc); m_valid = 1;
                m_idpc  = m_pc; m_idpc1 = (m_pc + 1) % 65536;
                m_pc    = (m_pc + 1) % 65536;
                m_fc    = sat(m_fc);
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("id_instr", id_instr, m_instr);
            chk("id_pc", id_pc, m_idpc);
            chk("id_pc_plus1", id_pc_plus1, m_idpc1);
            chk("id_valid", id_valid, m_valid);
            chk("fetch_count", fetch_count, m_fc);
            chk("kill_count", kill_count, m_kc);
            chk("stall_count", stall_count, m_sc);
        end
    end

    task automatic cyc(input logic r, st, k, input logic [1:0] s,
                       input logic [15:0] jt, bt, rt);
        reset = r; stall = st; kill = k; pc_src = s;
        jump_target = jt; branch_target = bt; ret_target = rt;
        @(negedge clk);
    endtask

    task automatic n();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 3, 16'h1111, 16'h2222, 16'h3333);
        chk("rst_pc", pc, 0); chk("rst_valid", id_valid, 0); chk("rst_fc", fetch_count, 0);
        n(); chk("first_instr", id_instr, 16'h1000); chk("first_pc", id_pc, 0);
        n(); chk("second_instr", id_instr, 16'h1001); chk("second_pc1", id_pc_plus1, 2);
        n(); chk("third_instr", id_instr, 16'h1002); chk("third_pc", id_pc, 2);
        chk("third_pc1", id_pc_plus1, 3); chk("fc3", fetch_count, 3);
        n(); n(); chk("pc5", pc, 5);
        cyc(0, 0, 1, 2, 16'h0, 16'h0040, 16'h0);
        chk("br_pc", pc, 16'h0040); chk("br_valid", id_valid, 0);
        chk("br_nop", id_instr, 0); chk("br_kc", kill_count, 1);
        n(); chk("br_target_instr", id_instr, 16'h1040); chk("br_target_valid", id_valid, 1);
        cyc(0, 0, 1, 1, 16'h0006, 16'h0, 16'h0);
        n(); n(); chk("pre_stall_idpc", id_pc, 7);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            chk("stall_idpc", id_pc, 7); chk("stall_pc", pc, 8); chk("stall_sc", stall_count, i);
        end
        n(); chk("resume_idpc", id_pc, 8); chk("resume_instr", id_instr, 16'h1008);
        cyc(0, 1, 1, 1, 16'h0020, 16'h0, 16'h0);
        chk("stallkill_pc", pc, 9); chk("stallkill_kc", kill_count, 2);
        cyc(0, 0, 1, 1, 16'h0020, 16'h0, 16'h0);
        chk("jump_pc", pc, 16'h0020);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0, 16'h0);
        n(); chk("wrap_pc", pc, 0); chk("wrap_idpc", id_pc, 16'hFFFF);
        chk("wrap_idpc1", id_pc_plus1, 0); chk("wrap_instr", id_instr, 16'h0FFF);
        cyc(0, 0, 1, 3, 16'h0, 16'h0, 16'h0123);
        chk("ret_pc", pc, 16'h0123);
        cyc(0, 0, 1, 0, 16'h5555, 16'h6666, 16'h7777);
        chk("seq_kill_pc", pc, 16'h0124); chk("seq_kill_idpc1", id_pc_plus1, 16'h0124);
        cyc(1, 0, 1, 2, 16'h0, 16'h0099, 16'h0);
        chk("rstkill_pc", pc, 0); chk("rstkill_kc", kill_count, 0);
        chk("rstkill_sc", stall_count, 0); chk("rstkill_idpc", id_pc, 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) n();
        chk("fc_saturated", fetch_count, 16'hFFFF);
        n(); chk("fc_held", fetch_count, 16'hFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
